npc_seq_ctrl: RTL and testbench



---
 rtl/npc_pkg.sv | 24 ++
 rtl/npc_fetch_timer.sv | 28 ++
 rtl/npc_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_npc_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC sequencer.
package npc_pkg;

  localparam int XLEN       = 64;
  localparam int INST_WIDTH = 32;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_WB         = 3'd4,
    S_HALT       = 3'd5
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_BUSERR  = 2'd3;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

endpackage

// File: rtl/npc_fetch_timer.sv
// 8-bit fetch timeout counter: cleared on request acceptance, counts
// response-less wait cycles, saturates, and flags the cycle whose
// increment would reach LIMIT.
module npc_fetch_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  // Count idle wait cycles; hold at all-ones so a stuck count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_inc && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
  end

  // Only fires on an idle cycle, so a response arriving at the limit wins.
  assign o_expire = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: fetch, decode,
// execute and writeback stepping, with sticky halt and cause code.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [XLEN-1:0] inst,
  input  logic            dec_is_addi,
  input  logic            dec_is_ebreak,
  output logic            alu_en,
  output logic            rf_wen,
  output logic [XLEN-1:0] pc,
  output logic            halt,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] retire_cnt
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_retire;
  logic            r_halt;
  logic [1:0]      r_cause;
  logic            r_alu_en;
  logic            r_rf_wen;

  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_tmr_expire;

  assign w_tmr_clr = (r_state == S_FETCH_REQ) && imem_req_ready;
  assign w_tmr_inc = (r_state == S_FETCH_WAIT) && !imem_rsp_valid;

  npc_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_tmr_clr),
    .i_inc    (w_tmr_inc),
    .o_expire (w_tmr_expire)
  );

  // Request is a Moore output of FETCH_REQ; masked while reset is held so
  // the bus sees no request before the sequencer is running.
  assign imem_req_valid = rst_n && (r_state == S_FETCH_REQ);
  assign imem_addr      = r_pc;
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign retire_cnt     = r_retire;
  assign halt           = r_halt;
  assign halt_cause     = r_cause;
  assign alu_en         = r_alu_en;
  assign rf_wen         = r_rf_wen;

  // Sequencer FSM; strobes are registered on entry to EXEC / WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH_REQ;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_retire <= '0;
      r_halt   <= 1'b0;
      r_cause  <= HALT_NONE;
      r_alu_en <= 1'b0;
      r_rf_wen <= 1'b0;
    end else begin
      r_alu_en <= 1'b0;
      r_rf_wen <= 1'b0;
      case (r_state)
        S_FETCH_REQ: begin
          if (imem_req_ready) r_state <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
              r_cause <= HALT_BUSERR;
            end else begin
              r_inst  <= {{(XLEN-INST_WIDTH){1'b0}}, imem_rsp_data};
              r_state <= S_DECODE;
            end
          end else if (w_tmr_expire) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_cause <= HALT_BUSERR;
          end
        end
        S_DECODE: begin
          if (dec_is_ebreak) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_cause <= HALT_EBREAK;
          end else if (dec_is_addi) begin
            r_state  <= S_EXEC;
            r_alu_en <= 1'b1;
          end else begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
            r_cause <= HALT_ILLEGAL;
          end
        end
        S_EXEC: begin
          r_state  <= S_WB;
          r_rf_wen <= (r_inst[11:7] != 5'd0);
        end
        S_WB: begin
          r_pc     <= r_pc + 64'd4;
          r_retire <= r_retire + 64'd1;
          r_state  <= S_FETCH_REQ;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_HALT;
          r_halt  <= 1'b1;
          r_cause <= HALT_ILLEGAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Scoreboard bench for npc_seq_ctrl: a program model pushes expected
// retire/halt events, a memory driver serves fetches, a monitor pops.
module tb_npc_seq_ctrl;
  import npc_pkg::*;

  localparam logic [63:0] RPC      = 64'h8000_0000;
  localparam int          FT       = 255;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam int          CLK_P    = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic [63:0] inst;
  logic        dec_is_addi, dec_is_ebreak;
  logic        alu_en, rf_wen, halt;
  logic [63:0] pc, retire_cnt;
  logic [1:0]  halt_cause;
  bit          tb_both = 1'b0;

  npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst(inst), .dec_is_addi(dec_is_addi), .dec_is_ebreak(dec_is_ebreak),
    .alu_en(alu_en), .rf_wen(rf_wen), .pc(pc), .halt(halt),
    .halt_cause(halt_cause), .retire_cnt(retire_cnt)
  );

  always #(CLK_P/2) clk = ~clk;

  function automatic bit is_addi(logic [31:0] w);
    return (w[6:0] == OP_IMM) && (w[14:12] == 3'b000);
  endfunction

  // Decoder stand-in; tb_both also raises addi on ebreak to test priority.
  always_comb begin
    dec_is_ebreak = (inst[31:0] == EBREAK_W);
    dec_is_addi   = is_addi(inst[31:0]) || (tb_both && (inst[31:0] == EBREAK_W));
  end

  typedef struct { int stall; int delay; bit err; logic [31:0] data; } fetch_t;
  typedef struct { bit hlt; logic [1:0] cause; logic [63:0] pc; logic [31:0] iw;
                   bit wen; logic [63:0] rcnt; int lat; } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] m_pc, m_rcnt;
  longint      acc_t = 0;
  int          wb_st = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Spec-level model: what one fetch attempt at m_pc must produce.
  function automatic bit model_push(input fetch_t f);
    exp_t e;
    e = '{hlt:1'b1, cause:HALT_NONE, pc:m_pc, iw:f.data, wen:1'b0, rcnt:m_rcnt, lat:0};
    if (f.err || f.delay > FT)  e.cause = HALT_BUSERR;
    else if (f.data == EBREAK_W) e.cause = HALT_EBREAK;
    else if (is_addi(f.data)) begin
      e.hlt  = 1'b0;
      e.wen  = (f.data[11:7] != 5'd0);
      e.rcnt = m_rcnt + 64'd1;
      e.lat  = f.delay + 2;
      m_pc   = m_pc + 64'd4;
      m_rcnt = m_rcnt + 64'd1;
    end else e.cause = HALT_ILLEGAL;
    exp_q.push_back(e);
    return e.hlt;
  endfunction

  function automatic fetch_t mk(int s, int d, bit er, logic [31:0] w);
    fetch_t f;
    f = '{stall:s, delay:d, err:er, data:w};
    return f;
  endfunction

  function automatic logic [31:0] gen_inst();
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 9);
    r = $urandom;
    if (k <= 6)      return {r[31:15], 3'b000, (k == 0) ? 5'd0 : 5'($urandom_range(1, 31)), OP_IMM};
    else if (k == 7) return EBREAK_W;
    else if (k == 8) return {r[31:15], 3'b001, r[11:7], OP_IMM};
    else             return {r[31:7], SYSTEM};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},      pc, RPC);
    chk({tag, "_inst"},    inst, 64'd0);
    chk({tag, "_retire"},  retire_cnt, 64'd0);
    chk({tag, "_halt"},    64'(halt), 64'd0);
    chk({tag, "_cause"},   64'(halt_cause), 64'(HALT_NONE));
    chk({tag, "_reqv"},    64'(imem_req_valid), 64'd0);
    chk({tag, "_alu_en"},  64'(alu_en), 64'd0);
    chk({tag, "_rf_wen"},  64'(rf_wen), 64'd0);
  endtask

  task automatic rst_pulse(input string tag);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals(tag);
    exp_q.delete();
    m_pc   = RPC;
    m_rcnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory side of one fetch: stall, accept once, respond after delay.
  task automatic run_fetch(input fetch_t f, input logic [63:0] epc);
    int k;
    logic [63:0] a0;
    k = 0;
    @(negedge clk);
    while (!imem_req_valid && k < 50) begin @(negedge clk); k++; end
    chk("req_seen", 64'(imem_req_valid), 64'd1);
    if (!imem_req_valid) return;
    chk("imem_addr", imem_addr, epc);
    a0 = imem_addr;
    for (int s = 0; s < f.stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_addr", imem_addr, a0);
    end
    imem_req_ready = 1'b1;
    @(posedge clk);
    acc_t = longint'($time);
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("single_accept", 64'(imem_req_valid), 64'd0);
    if (f.delay <= FT) begin
      repeat (f.delay - 1) @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = f.err;
      imem_rsp_data  = f.data;
      @(negedge clk);
    end else begin
      repeat (FT + 3) @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = f.data;
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = $urandom;
  endtask

  task automatic run_prog(input fetch_t prog[$]);
    bit h;
    int k, busy;
    h = 1'b0;
    foreach (prog[i]) begin
      logic [63:0] epc;
      epc = m_pc;
      h = model_push(prog[i]);
      run_fetch(prog[i], epc);
      if (h) break;
    end
    if (h) begin
      k = 0;
      while (!halt && k < 300) begin @(negedge clk); k++; end
      chk("halt_reached", 64'(halt), 64'd1);
      busy = 0;
      repeat (20) begin
        @(negedge clk);
        if (imem_req_valid || alu_en || rf_wen) busy++;
      end
      chk("quiet_after_halt", 64'(busy), 64'd0);
    end else begin
      k = 0;
      while ((exp_q.size() != 0 || wb_st != 0) && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops an expectation whenever the DUT retires or halts.
  initial begin : monitor
    exp_t cur;
    bit   hseen;
    hseen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wb_st = 0;
        hseen = 1'b0;
      end else begin
        chk("strobe_excl", 64'((32'(alu_en) + 32'(rf_wen) + 32'(imem_req_valid)) > 1), 64'd0);
        if (wb_st == 2) begin
          chk("wb_pc", pc, cur.pc + 64'd4);
          chk("wb_retire", retire_cnt, cur.rcnt);
          wb_st = 0;
        end
        if (wb_st == 1) begin
          chk("rf_wen", 64'(rf_wen), 64'(cur.wen));
          chk("alu_en_one_cycle", 64'(alu_en), 64'd0);
          wb_st = 2;
        end else if (alu_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_retire: got alu_en at pc %0h expected no event", pc);
          end else begin
            cur = exp_q.pop_front();
            chk("event_is_retire", 64'(cur.hlt), 64'd0);
            chk("exec_pc", pc, cur.pc);
            chk("exec_inst", inst, {32'd0, cur.iw});
            chk("exec_time", 64'($time), 64'(acc_t + longint'(CLK_P * cur.lat) - longint'(CLK_P / 2)));
            wb_st = 1;
          end
        end
        if (halt && !hseen) begin
          hseen = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_halt: got cause %0d expected no event", halt_cause);
          end else begin
            cur = exp_q.pop_front();
            chk("event_is_halt", 64'(cur.hlt), 64'd1);
            chk("halt_cause", 64'(halt_cause), 64'(cur.cause));
            chk("halt_pc", pc, cur.pc);
            chk("halt_retire", retire_cnt, cur.rcnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
    $fatal(1);
  end

  initial begin : stim
    fetch_t p[$];
    int k;
    fetch_t f;

    @(negedge clk);
    rst_pulse("reset");
    run_prog('{mk(0, 1, 0, 32'h0050_0093)});            // addi x1,x0,5
    chk("first_pc", pc, RPC + 64'd4);
    chk("first_retire", retire_cnt, 64'd1);

    rst_pulse("rst_b");
    run_prog('{mk(3, 2, 0, 32'h0050_0093)});            // stalled accept, 2-cycle rsp
    rst_pulse("rst_c");
    run_prog('{mk(0, 1, 0, 32'h0000_0013)});            // addi x0: no rf_wen
    rst_pulse("rst_d");
    run_prog('{mk(0, 1, 0, EBREAK_W)});
    rst_pulse("rst_e");
    run_prog('{mk(0, 1, 0, 32'h0050_0093), mk(1, 3, 1, 32'h0050_0093)});
    rst_pulse("rst_f");
    run_prog('{mk(0, FT + 1, 0, 32'h0050_0093)});       // timeout
    rst_pulse("rst_g");
    run_prog('{mk(0, FT, 0, 32'h0010_0093), mk(0, 1, 0, 32'h0000_0073)});
    tb_both = 1'b1;
    rst_pulse("rst_h");
    run_prog('{mk(0, 1, 0, 32'h0050_0093), mk(0, 1, 0, EBREAK_W)});
    tb_both = 1'b0;

    // Reset in FETCH_WAIT, then a stray response while in FETCH_REQ.
    rst_pulse("rst_i");
    run_prog('{mk(0, 1, 0, 32'h0070_0113)});
    k = 0;
    while (!imem_req_valid && k < 10) begin @(negedge clk); k++; end
    imem_req_ready = 1'b1;
    @(posedge clk);
    #2 imem_req_ready = 1'b0;
    rst_pulse("rst_in_wait");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("late_rsp_inst", inst, 64'd0);
    chk("late_rsp_reqv", 64'(imem_req_valid), 64'd1);
    run_prog('{mk(1, 1, 0, 32'h0050_0093)});
    chk("refetch_retire", retire_cnt, 64'd1);

    // Reset during WB.
    rst_pulse("rst_j");
    f = mk(0, 1, 0, 32'h00A0_0193);
    void'(model_push(f));
    run_fetch(f, RPC);
    k = 0;
    while (!rf_wen && k < 10) begin @(negedge clk); k++; end
    chk("wb_reached", 64'(rf_wen), 64'd1);
    #1 rst_pulse("rst_in_wb");
    run_prog('{mk(0, 1, 0, 32'h0010_0093)});
    chk("wb_refetch_pc", pc, RPC + 64'd4);

    // Random programs.
    for (int n = 0; n < 12; n++) begin
      int len, r;
      tb_both = bit'($urandom_range(0, 1));
      rst_pulse("rst_rand");
      p.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        f.stall = $urandom_range(0, 3);
        f.delay = (r == 0) ? FT : (r == 1) ? FT + 1 : $urandom_range(1, 4);
        f.err   = ($urandom_range(0, 15) == 0);
        f.data  = gen_inst();
        p.push_back(f);
      end
      run_prog(p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
